writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Writeback stage directly upstream of the core register file; sole producer of its write port (reg_wr, waddr, wdata).
- Merges single-cycle ALU results with variable-latency, in-order load responses from the L1 data cache.
- Keeps an in-order load tag queue and a per-register pending scoreboard, and gives decode a RAW stall signal.
- Aligns and sign/zero-extends load data before writeback.

Parameters:
LQ_DEPTH, 4, outstanding-load tag queue depth; power of two, >= 2

Ports:
clk  in  1  core clock; all state on posedge
reset  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result offered
alu_rd  in  5  ALU destination register
alu_result  in  32  ALU result
alu_ready  out  1  ALU result accepted this cycle when alu_valid&alu_ready
load_issue  in  1  load sent to cache; push tag
load_rd  in  5  load destination register
load_funct3  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
load_byte_off  in  2  address[1:0] of the load
load_issue_ready  out  1  tag push permitted
mem_rvalid  in  1  cache load response, in issue order
mem_rdata  in  32  aligned 32-bit word from cache
raddr1  in  5  decode source register 1
raddr2  in  5  decode source register 2
raw_stall  out  1  raddr1 or raddr2 (non-zero) has a pending load
reg_wr  out  1  register file write enable
waddr  out  5  register file write address
wdata  out  32  register file write data

Behaviour:
- Reset (reset low, asynchronous): queue empty, scoreboard clear, skid buffer empty.
- Outputs during reset: reg_wr=0, waddr=0, wdata=0.
- Registered outputs: reg_wr/waddr/wdata update on posedge. The register file captures on the following negedge, so the written value is readable in the next cycle.
- Tag queue: circular buffer of LQ_DEPTH entries {rd, funct3, byte_off}; pointers carry one extra wrap bit.
  - load_issue_ready = !full && !pending[load_rd].
  - Push on load_issue && load_issue_ready. load_issue while not ready is dropped; the upstream stage must hold the load.
- Scoreboard: 32 pending bits.
  - Set on push when load_rd != 0.
  - Cleared when that load's writeback is registered.
  - pending[0] is always 0.
  - Same-cycle push and pop of the same rd cannot occur: issue is blocked while that rd is pending.
- raw_stall = (raddr1!=0 && pending[raddr1]) || (raddr2!=0 && pending[raddr2]). Combinational.
- Load completion: mem_rvalid with queue non-empty pops the head and forms data.
  - lb/lbu: byte at lane byte_off.
  - lh/lhu: halfword at lane byte_off[1].
  - lw and reserved funct3 codes (011, 110, 111): full word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Next cycle: reg_wr = (rd!=0), waddr = rd, wdata = extended data.
- mem_rvalid with queue empty: ignored; no state change.
- ALU path: one-entry skid buffer.
  - alu_ready = !skid_full && !(alu_rd!=0 && pending[alu_rd]). Holding ALU writes behind a pending load to the same rd preserves write-after-write order.
  - Accepted ALU results to rd=0 are consumed with no write.
- Arbitration per cycle, load response has highest priority:
  - If a load pops: an accepted ALU result, or one already in the skid buffer, stays in or enters the skid buffer.
  - Otherwise the skid buffer drains first.
  - Otherwise a newly accepted ALU result is written directly.
  - Exactly one write is registered per cycle.
- Write to rd=0 from either source: reg_wr=0 and waddr=0 for that cycle; the source is still consumed.
- Simultaneous push and pop with the queue full: the push is refused because load_issue_ready=0; the pop proceeds.
- Reset mid-operation: all pending loads and the skid entry are discarded. Responses that arrive after reset release are ignored, since the queue is empty.

Optional Feature:
- Macro: WB_PROTOCOL_CHECK_EN.
- When defined: adds output wb_err (1 bit), reset to 0. It is set sticky on:
  - mem_rvalid with the queue empty;
  - load_issue while load_issue_ready=0.
  - Cleared only by reset.
- When undefined: no wb_err port; both events are silently ignored as above.

Test Plan:
- ALU only: alu_valid, rd=5, result 0x1234_5678 -> next cycle reg_wr=1, waddr=5, wdata=0x1234_5678; alu_ready stays 1.
- Load extension: issue lb rd=7 off=3, then mem_rdata=0x80AA_BBCC -> wdata=0xFFFF_FF80. Same for lbu -> 0x0000_0080; lh off=2 -> 0xFFFF_80AA; lw -> 0x80AA_BBCC.
- Collision: mem_rvalid (load rd=3) and ALU rd=4 in the same cycle -> cycle N+1 writes rd=3; cycle N+2 writes rd=4 from the skid. alu_ready=0 in N+1 if a new ALU result is offered while the skid is full.
- Full/RAW: issue 4 loads (rd=1..4) -> load_issue_ready=0. raddr1=2 -> raw_stall=1. One response -> ready=1, pending[1] clears, raw_stall with raddr1=1 = 0.
- Hazards/x0: load rd=9 pending, then ALU rd=9 offered -> alu_ready=0 until the load is written. Load to rd=0 -> reg_wr=0, pop still occurs.
- Reset mid-flight: 2 loads pending, reset low -> reg_wr=0 and raw_stall=0 immediately. A post-release mem_rvalid causes no write, and wb_err=1 if WB_PROTOCOL_CHECK_EN is defined.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and in-order load responses into the register file write port.
// Optional WB_PROTOCOL_CHECK_EN adds a sticky wb_err output for protocol violations.
module writeback_unit #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  output logic        alu_ready,
  input  logic        load_issue,
  input  logic [4:0]  load_rd,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_byte_off,
  output logic        load_issue_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        raw_stall,
  output logic        reg_wr,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
`ifdef WB_PROTOCOL_CHECK_EN
  ,
  output logic        wb_err
`endif
);

  localparam int AW = $clog2(LQ_DEPTH);

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] byte_off;
  } tag_t;

  tag_t        tag_q [LQ_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        q_empty, q_full;
  logic        push, pop, alu_acc;
  tag_t        head;

  logic [31:0] pending, pending_nxt;

  logic        skid_full;
  logic [4:0]  skid_rd;
  logic [31:0] skid_data;

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_data;

  logic        wr_valid;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        skid_load, skid_drain;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = tag_q[rd_ptr[AW-1:0]];

  assign load_issue_ready = !q_full && !pending[load_rd];
  assign alu_ready        = !skid_full && !((alu_rd != 5'd0) && pending[alu_rd]);
  assign raw_stall        = ((raddr1 != 5'd0) && pending[raddr1]) ||
                            ((raddr2 != 5'd0) && pending[raddr2]);

  assign push    = load_issue && load_issue_ready;
  assign pop     = mem_rvalid && !q_empty;
  assign alu_acc = alu_valid && alu_ready;

  // NOTE: the tag storage has no reset; entries are only read once the pointers mark them valid.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr[AW-1:0]] <= '{rd: load_rd, funct3: load_funct3, byte_off: load_byte_off};
  end

  // Lane selection and sign/zero extension of the load response.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    byte_v  = mem_rdata[7:0];
    ld_data = mem_rdata;
    case (head.byte_off)
      2'd1:    byte_v = mem_rdata[15:8];
      2'd2:    byte_v = mem_rdata[23:16];
      2'd3:    byte_v = mem_rdata[31:24];
      default: byte_v = mem_rdata[7:0];
    endcase
    half_v = head.byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (head.funct3)
      3'b000:  ld_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_data = {{16{half_v[15]}}, half_v};
      3'b100:  ld_data = {24'd0, byte_v};
      3'b101:  ld_data = {16'd0, half_v};
      default: ld_data = mem_rdata;
    endcase
  end

  // Load response wins; a colliding ALU result parks in the skid buffer.
  always_comb begin
    wr_valid   = 1'b0;
    wr_rd      = 5'd0;
    wr_data    = 32'd0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (pop) begin
      wr_valid  = 1'b1;
      wr_rd     = head.rd;
      wr_data   = ld_data;
      skid_load = alu_acc;
    end else if (skid_full) begin
      wr_valid   = 1'b1;
      wr_rd      = skid_rd;
      wr_data    = skid_data;
      skid_drain = 1'b1;
    end else if (alu_acc) begin
      wr_valid = 1'b1;
      wr_rd    = alu_rd;
      wr_data  = alu_result;
    end
  end

  always_comb begin
    pending_nxt = pending;
    if (pop)                        pending_nxt[head.rd] = 1'b0;
    if (push && (load_rd != 5'd0))  pending_nxt[load_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pending   <= '0;
      skid_full <= 1'b0;
      skid_rd   <= 5'd0;
      skid_data <= 32'd0;
      reg_wr    <= 1'b0;
      waddr     <= 5'd0;
      wdata     <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      pending <= pending_nxt;
      if (skid_load) begin
        skid_full <= 1'b1;
        skid_rd   <= alu_rd;
        skid_data <= alu_result;
      end else if (skid_drain) begin
        skid_full <= 1'b0;
      end
      if (wr_valid && (wr_rd != 5'd0)) begin
        reg_wr <= 1'b1;
        waddr  <= wr_rd;
        wdata  <= wr_data;
      end else begin
        reg_wr <= 1'b0;
        waddr  <= 5'd0;
        wdata  <= 32'd0;
      end
    end
  end

`ifdef WB_PROTOCOL_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_err <= 1'b0;
    end else if ((mem_rvalid && q_empty) || (load_issue && !load_issue_ready)) begin
      wb_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a randomized run
// against a transaction-level model (queue of loads, pending set, one skid slot).
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        load_issue;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_byte_off;
  logic        load_issue_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  raddr1, raddr2;
  logic        raw_stall;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
`ifdef WB_PROTOCOL_CHECK_EN
  logic        wb_err;
`endif

  int checks = 0;
  int errors = 0;

  writeback_unit #(.LQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
    .load_issue(load_issue), .load_rd(load_rd), .load_funct3(load_funct3),
    .load_byte_off(load_byte_off), .load_issue_ready(load_issue_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .raddr1(raddr1), .raddr2(raddr2), .raw_stall(raw_stall),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata)
`ifdef WB_PROTOCOL_CHECK_EN
    , .wb_err(wb_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    load_issue = 0; load_rd = 0; load_funct3 = 0; load_byte_off = 0;
    mem_rvalid = 0; mem_rdata = 0; raddr1 = 0; raddr2 = 0;
  endtask

  // Inputs change 1ns after the rising edge; registered outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * off));
    h = 16'(w >> (16 * off[1]));
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic test_reset();
    idle();
    reset = 0;
    tick(); tick();
    raddr1 = 5'd3; raddr2 = 5'd17;
    #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL reset_reg_wr got %b exp 0", reg_wr); end
    checks++; if (waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", waddr); end
    checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", wdata); end
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL reset_raw_stall got %b exp 0", raw_stall); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b exp 1", alu_ready); end
    checks++; if (load_issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b exp 1", load_issue_ready); end
`ifdef WB_PROTOCOL_CHECK_EN
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got %b exp 0", wb_err); end
`endif
    tick();
    reset = 1;
    idle();
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5'd5; alu_result = 32'h1234_5678;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b exp 1", alu_ready); end
    tick();
    alu_valid = 0;
    checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL alu_reg_wr got %b exp 1", reg_wr); end
    checks++; if (waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0d exp 5", waddr); end
    checks++; if (wdata !== 32'h1234_5678) begin errors++; $display("FAIL alu_wdata got %h exp 12345678", wdata); end
    tick();
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL alu_idle_reg_wr got %b exp 0", reg_wr); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b110};
    logic [1:0]  offs [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1};
    logic [31:0] exps [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AA,
                              32'h80AA_BBCC, 32'h0000_BBCC, 32'h80AA_BBCC};
    for (int i = 0; i < 6; i++) begin
      load_issue = 1; load_rd = 5'd7; load_funct3 = f3s[i]; load_byte_off = offs[i];
      #1;
      checks++; if (load_issue_ready !== 1'b1) begin errors++; $display("FAIL ext%0d_issue_ready got %b exp 1", i, load_issue_ready); end
      tick();
      load_issue = 0;
      mem_rvalid = 1; mem_rdata = 32'h80AA_BBCC;
      tick();
      mem_rvalid = 0;
      checks++; if (reg_wr !== 1'b1 || waddr !== 5'd7) begin errors++; $display("FAIL ext%0d_write got wr=%b addr=%0d exp wr=1 addr=7", i, reg_wr, waddr); end
      checks++; if (wdata !== exps[i]) begin errors++; $display("FAIL ext%0d_wdata got %h exp %h", i, wdata, exps[i]); end
    end
  endtask

  task automatic test_collision();
    load_issue = 1; load_rd = 5'd3; load_funct3 = 3'b010; load_byte_off = 0;
    tick();
    load_issue = 0;
    mem_rvalid = 1; mem_rdata = 32'hDEAD_0003;
    alu_valid = 1; alu_rd = 5'd4; alu_result = 32'h0000_000A;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL coll_alu_ready_n got %b exp 1", alu_ready); end
    tick();
    mem_rvalid = 0;
    alu_rd = 5'd6; alu_result = 32'h0000_000B;
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd3 || wdata !== 32'hDEAD_0003) begin errors++; $display("FAIL coll_load_first got wr=%b addr=%0d data=%h exp wr=1 addr=3 data=dead0003", reg_wr, waddr, wdata); end
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL coll_skid_full_ready got %b exp 0", alu_ready); end
    tick();
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd4 || wdata !== 32'h0000_000A) begin errors++; $display("FAIL coll_skid_drain got wr=%b addr=%0d data=%h exp wr=1 addr=4 data=0000000a", reg_wr, waddr, wdata); end
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL coll_ready_after_drain got %b exp 1", alu_ready); end
    tick();
    alu_valid = 0;
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd6 || wdata !== 32'h0000_000B) begin errors++; $display("FAIL coll_next_alu got wr=%b addr=%0d data=%h exp wr=1 addr=6 data=0000000b", reg_wr, waddr, wdata); end
    tick();
  endtask

  task automatic test_full_raw();
    for (int i = 1; i <= 4; i++) begin
      load_issue = 1; load_rd = 5'(i); load_funct3 = 3'b010; load_byte_off = 0;
      #1;
      checks++; if (load_issue_ready !== 1'b1) begin errors++; $display("FAIL full_issue%0d_ready got %b exp 1", i, load_issue_ready); end
      tick();
    end
    load_issue = 0; load_rd = 5'd5;
    raddr1 = 5'd2;
    #1;
    checks++; if (load_issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", load_issue_ready); end
    checks++; if (raw_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_r2 got %b exp 1", raw_stall); end
    mem_rvalid = 1; mem_rdata = 32'h1111_0001;
    tick();
    mem_rvalid = 0;
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd1 || wdata !== 32'h1111_0001) begin errors++; $display("FAIL full_pop1 got wr=%b addr=%0d data=%h exp wr=1 addr=1 data=11110001", reg_wr, waddr, wdata); end
    raddr1 = 5'd1;
    #1;
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL raw_stall_r1_cleared got %b exp 0", raw_stall); end
    checks++; if (load_issue_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got %b exp 1", load_issue_ready); end
    raddr1 = 0;
    for (int i = 2; i <= 4; i++) begin
      mem_rvalid = 1; mem_rdata = 32'h1111_0000 + 32'(i);
      tick();
      mem_rvalid = 0;
      checks++; if (reg_wr !== 1'b1 || waddr !== 5'(i) || wdata !== 32'h1111_0000 + 32'(i)) begin errors++; $display("FAIL full_pop%0d got wr=%b addr=%0d data=%h", i, reg_wr, waddr, wdata); end
    end
    idle();
  endtask

  task automatic test_hazard_x0();
    load_issue = 1; load_rd = 5'd9; load_funct3 = 3'b010; load_byte_off = 0;
    tick();
    load_issue = 0;
    alu_valid = 1; alu_rd = 5'd9; alu_result = 32'hCAFE_0009;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL waw_ready_pending got %b exp 0", alu_ready); end
    tick();
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL waw_no_write got %b exp 0", reg_wr); end
    mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL waw_ready_popcycle got %b exp 0", alu_ready); end
    tick();
    mem_rvalid = 0;
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL waw_load_write got wr=%b addr=%0d data=%h exp wr=1 addr=9 data=0badf00d", reg_wr, waddr, wdata); end
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL waw_ready_after got %b exp 1", alu_ready); end
    tick();
    alu_valid = 0;
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd9 || wdata !== 32'hCAFE_0009) begin errors++; $display("FAIL waw_alu_write got wr=%b addr=%0d data=%h exp wr=1 addr=9 data=cafe0009", reg_wr, waddr, wdata); end
    load_issue = 1; load_rd = 5'd0;
    tick();
    load_rd = 5'd8;
    tick();
    load_issue = 0;
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    tick();
    checks++; if (reg_wr !== 1'b0 || waddr !== 5'd0) begin errors++; $display("FAIL x0_load got wr=%b addr=%0d exp wr=0 addr=0", reg_wr, waddr); end
    mem_rdata = 32'h7777_0008;
    tick();
    mem_rvalid = 0;
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd8 || wdata !== 32'h7777_0008) begin errors++; $display("FAIL x0_popped got wr=%b addr=%0d data=%h exp wr=1 addr=8 data=77770008", reg_wr, waddr, wdata); end
    alu_valid = 1; alu_rd = 5'd0; alu_result = 32'hFFFF_FFFF;
    tick();
    alu_valid = 0;
    checks++; if (reg_wr !== 1'b0 || waddr !== 5'd0) begin errors++; $display("FAIL x0_alu got wr=%b addr=%0d exp wr=0 addr=0", reg_wr, waddr); end
    idle();
    tick();
  endtask

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } ld_t;

  task automatic test_random();
    ld_t         mq[$];
    bit          pend[32];
    bit          sk_v = 0;
    logic [4:0]  sk_rd = 0;
    logic [31:0] sk_data = 0;
    bit          e_ar, e_ir, e_rs, do_pop, do_push, do_acc, e_wv;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    ld_t         h;
    for (int i = 0; i < 32; i++) pend[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit quiet;
      quiet = (cyc >= 560);
      alu_valid     = !quiet && ($urandom_range(0, 1) == 1);
      alu_rd        = 5'($urandom_range(0, 7));
      alu_result    = $urandom;
      load_issue    = !quiet && ($urandom_range(0, 1) == 1);
      load_rd       = 5'($urandom_range(0, 7));
      load_funct3   = 3'($urandom_range(0, 7));
      load_byte_off = 2'($urandom_range(0, 3));
      mem_rvalid    = quiet ? (mq.size() > 0) : ($urandom_range(0, 9) < 4);
      mem_rdata     = $urandom;
      raddr1        = 5'($urandom_range(0, 8));
      raddr2        = 5'($urandom_range(0, 8));
      #1;
      e_ar = !sk_v && !(alu_rd != 0 && pend[alu_rd]);
      e_ir = (mq.size() < 4) && !pend[load_rd];
      e_rs = (raddr1 != 0 && pend[raddr1]) || (raddr2 != 0 && pend[raddr2]);
      checks++; if (alu_ready !== e_ar) begin errors++; $display("FAIL rnd%0d_alu_ready got %b exp %b", cyc, alu_ready, e_ar); end
      checks++; if (load_issue_ready !== e_ir) begin errors++; $display("FAIL rnd%0d_issue_ready got %b exp %b", cyc, load_issue_ready, e_ir); end
      checks++; if (raw_stall !== e_rs) begin errors++; $display("FAIL rnd%0d_raw_stall got %b exp %b", cyc, raw_stall, e_rs); end
      do_pop  = mem_rvalid && (mq.size() > 0);
      do_push = load_issue && e_ir;
      do_acc  = alu_valid && e_ar;
      e_wv = 0; e_rd = 0; e_data = 0;
      if (do_pop) begin
        h = mq.pop_front();
        e_wv = 1; e_rd = h.rd; e_data = ext_model(h.f3, h.off, mem_rdata);
        pend[h.rd] = 0;
        if (do_acc) begin sk_v = 1; sk_rd = alu_rd; sk_data = alu_result; end
      end else if (sk_v) begin
        e_wv = 1; e_rd = sk_rd; e_data = sk_data; sk_v = 0;
      end else if (do_acc) begin
        e_wv = 1; e_rd = alu_rd; e_data = alu_result;
      end
      if (do_push) begin
        mq.push_back('{rd: load_rd, f3: load_funct3, off: load_byte_off});
        if (load_rd != 0) pend[load_rd] = 1;
      end
      tick();
      if (e_wv && e_rd != 0) begin
        checks++; if (reg_wr !== 1'b1 || waddr !== e_rd || wdata !== e_data) begin errors++; $display("FAIL rnd%0d_write got wr=%b addr=%0d data=%h exp wr=1 addr=%0d data=%h", cyc, reg_wr, waddr, wdata, e_rd, e_data); end
      end else if (e_wv) begin
        checks++; if (reg_wr !== 1'b0 || waddr !== 5'd0) begin errors++; $display("FAIL rnd%0d_x0 got wr=%b addr=%0d exp wr=0 addr=0", cyc, reg_wr, waddr); end
      end else begin
        checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle got wr=%b exp 0", cyc, reg_wr); end
      end
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_reset_midflight();
    load_issue = 1; load_rd = 5'd10; load_funct3 = 3'b010; load_byte_off = 0;
    tick();
    load_rd = 5'd11;
    alu_valid = 1; alu_rd = 5'd12; alu_result = 32'h0000_0C0C;
    tick();
    idle();
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd12) begin errors++; $display("FAIL mid_pre_write got wr=%b addr=%0d exp wr=1 addr=12", reg_wr, waddr); end
    raddr1 = 5'd10;
    #1;
    checks++; if (raw_stall !== 1'b1) begin errors++; $display("FAIL mid_raw_before got %b exp 1", raw_stall); end
    reset = 0;
    #1;
    checks++; if (reg_wr !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin errors++; $display("FAIL mid_reset_outputs got wr=%b addr=%0d data=%h exp all 0", reg_wr, waddr, wdata); end
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL mid_reset_raw got %b exp 0", raw_stall); end
    tick(); tick();
    reset = 1;
    mem_rvalid = 1; mem_rdata = 32'h9999_9999;
    tick();
    mem_rvalid = 0;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL mid_stale_resp got wr=%b exp 0", reg_wr); end
    #1;
    checks++; if (raw_stall !== 1'b0) begin errors++; $display("FAIL mid_raw_after got %b exp 0", raw_stall); end
`ifdef WB_PROTOCOL_CHECK_EN
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL mid_wb_err got %b exp 1", wb_err); end
`endif
    idle();
    tick();
  endtask

  initial begin
    idle();
    reset = 0;
    test_reset();
    test_alu();
    test_load_ext();
    test_collision();
    test_full_raw();
    test_hazard_x0();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
